// File: rtl/wshb_if.sv
// Wishbone B4 classic bus bundle shared by the requesters and the slave.
// dat_ms carries master-to-slave data, dat_sm carries slave-to-master data.
interface wshb_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 32
);
   logic          cyc;
   logic          stb;
   logic          we;
   logic [AW-1:0] adr;
   logic [DW/8-1:0] sel;
   logic [DW-1:0] dat_ms;
   logic [DW-1:0] dat_sm;
   logic          ack;
   logic          err;
   logic          rty;

   modport master (
      output cyc, stb, we, adr, sel, dat_ms,
      input  dat_sm, ack, err, rty
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_ms,
      output dat_sm, ack, err, rty
   );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-requester Wishbone arbiter: round-robin ownership of one shared slave,
// combinational pass-through while owned, and a stalled-strobe watchdog.
module wb_arbiter_2m #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   wshb_if.slave      wb_m0,
   wshb_if.slave      wb_m1,
   wshb_if.master     wb_s,
   output logic [1:0] grant
);

   localparam int unsigned     CntW   = 10;
   localparam logic [CntW-1:0] WdLast = CntW'(TIMEOUT - 1);

   if (TIMEOUT < 2 || TIMEOUT > 1023) begin : g_timeout_range
      $error("wb_arbiter_2m: TIMEOUT must be within 2..1023");
   end

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StOwn0 = 2'd1,
      StOwn1 = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            last_m1_q, last_m1_d;
   logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
   logic            own0, own1;
   logic            own_stb;
   logic            slave_resp;
   logic            wd_hit;
   logic            wd_err;

   // State register; last_m1 resets high so m0 wins the first contest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         last_m1_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         last_m1_q <= last_m1_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (wb_m0.cyc && wb_m1.cyc) begin
               state_d = last_m1_q ? StOwn0 : StOwn1;
            end else if (wb_m0.cyc) begin
               state_d = StOwn0;
            end else if (wb_m1.cyc) begin
               state_d = StOwn1;
            end
         end
         StOwn0: if (!wb_m0.cyc) state_d = StIdle;
         StOwn1: if (!wb_m1.cyc) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      last_m1_d = last_m1_q;
      if (state_d == StOwn0) last_m1_d = 1'b0;
      if (state_d == StOwn1) last_m1_d = 1'b1;
   end

   assign own0       = (state_q == StOwn0);
   assign own1       = (state_q == StOwn1);
   assign own_stb    = (own0 && wb_m0.stb) || (own1 && wb_m1.stb);
   assign slave_resp = wb_s.ack || wb_s.err || wb_s.rty;

   // The hit is independent of the slave response so a combinational-ack
   // slave cannot close a loop through the forced-low strobe.
   assign wd_hit = own_stb && (wd_cnt_q == WdLast);
   assign wd_err = wd_hit && !wb_s.ack && !wb_s.rty;

   // Request path towards the slave, plus the state-decoded grant.
   always_comb begin
      grant       = 2'b00;
      wb_s.cyc    = 1'b0;
      wb_s.stb    = 1'b0;
      wb_s.we     = 1'b0;
      wb_s.adr    = '0;
      wb_s.sel    = '0;
      wb_s.dat_ms = '0;
      unique case (state_q)
         StOwn0: begin
            grant       = 2'b01;
            wb_s.cyc    = wb_m0.cyc;
            wb_s.stb    = wb_m0.stb && !wd_hit;
            wb_s.we     = wb_m0.we;
            wb_s.adr    = wb_m0.adr;
            wb_s.sel    = wb_m0.sel;
            wb_s.dat_ms = wb_m0.dat_ms;
         end
         StOwn1: begin
            grant       = 2'b10;
            wb_s.cyc    = wb_m1.cyc;
            wb_s.stb    = wb_m1.stb && !wd_hit;
            wb_s.we     = wb_m1.we;
            wb_s.adr    = wb_m1.adr;
            wb_s.sel    = wb_m1.sel;
            wb_s.dat_ms = wb_m1.dat_ms;
         end
         default: ;
      endcase
   end

   // Response path; kept apart from the request path to avoid a false loop.
   always_comb begin
      wb_m0.ack    = 1'b0;
      wb_m0.err    = 1'b0;
      wb_m0.rty    = 1'b0;
      wb_m0.dat_sm = '0;
      wb_m1.ack    = 1'b0;
      wb_m1.err    = 1'b0;
      wb_m1.rty    = 1'b0;
      wb_m1.dat_sm = '0;
      if (own0) begin
         wb_m0.ack    = wb_s.ack;
         wb_m0.err    = wb_s.err || wd_err;
         wb_m0.rty    = wb_s.rty;
         wb_m0.dat_sm = wb_s.dat_sm;
      end
      if (own1) begin
         wb_m1.ack    = wb_s.ack;
         wb_m1.err    = wb_s.err || wd_err;
         wb_m1.rty    = wb_s.rty;
         wb_m1.dat_sm = wb_s.dat_sm;
      end
   end

   always_comb begin
      if (state_d != state_q || !own_stb || slave_resp || wd_hit) begin
         wd_cnt_d = '0;
      end else begin
         wd_cnt_d = wd_cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
      end
   end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: vector table for single-cycle behaviour,
// hand sequences for watchdog, ack-vs-watchdog and asynchronous reset.
module tb_wb_arbiter_2m;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] grant;
   logic       slv_en, slv_err, slv_rty, slv_init;
   logic       rd_ack_q = 1'b0;
   logic [31:0] rd_dat_q;
   logic [31:0] mem [64];
   int         ncmp = 0;
   int         nfail = 0;

   wshb_if m0_if ();
   wshb_if m1_if ();
   wshb_if s_if ();

   wb_arbiter_2m #(.TIMEOUT(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb_m0 (m0_if),
      .wb_m1 (m1_if),
      .wb_s  (s_if),
      .grant (grant)
   );

   always #5 clk = ~clk;

   // Slave: writes ack in the strobe cycle, reads ack one cycle later.
   assign s_if.ack    = (slv_en && s_if.cyc && s_if.stb && s_if.we) || rd_ack_q;
   assign s_if.err    = slv_err;
   assign s_if.rty    = slv_rty;
   assign s_if.dat_sm = rd_ack_q ? rd_dat_q : 32'h0;

   always @(posedge clk) begin
      if (slv_init) begin
         mem[8]  <= 32'hAABBCCDD;
         mem[12] <= 32'h5A5A0001;
      end else if (slv_en && s_if.cyc && s_if.stb && s_if.we) begin
         for (int b = 0; b < 4; b++)
            if (s_if.sel[b]) mem[s_if.adr[7:2]][8*b +: 8] <= s_if.dat_ms[8*b +: 8];
      end
      rd_ack_q <= slv_en && s_if.cyc && s_if.stb && !s_if.we && !rd_ack_q;
      rd_dat_q <= mem[s_if.adr[7:2]];
   end

   typedef struct packed {
      logic [3:0]  ctl;   // {rst_n, slave enable, slave err, slave rty}
      logic [5:0]  req;   // {cyc1, cyc0, stb1, stb0, we1, we0}
      logic [31:0] adr0;
      logic [31:0] dat0;
      logic [3:0]  sel0;
      logic [31:0] adr1;
      logic [31:0] dat1;
      logic [3:0]  sel1;
      logic [3:0]  bus;   // expected {grant, s.cyc, s.stb}
      logic [5:0]  rsp;   // expected {ack1, ack0, err1, err0, rty1, rty0}
      logic [31:0] dsm0;
      logic [31:0] dsm1;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
      ncmp++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst_n        = v.ctl[3];
      slv_en       = v.ctl[2];
      slv_err      = v.ctl[1];
      slv_rty      = v.ctl[0];
      m1_if.cyc    = v.req[5];
      m0_if.cyc    = v.req[4];
      m1_if.stb    = v.req[3];
      m0_if.stb    = v.req[2];
      m1_if.we     = v.req[1];
      m0_if.we     = v.req[0];
      m0_if.adr    = v.adr0;
      m0_if.dat_ms = v.dat0;
      m0_if.sel    = v.sel0;
      m1_if.adr    = v.adr1;
      m1_if.dat_ms = v.dat1;
      m1_if.sel    = v.sel1;
   endtask

   task automatic masters_off();
      m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0;
      m0_if.adr = 32'h0; m0_if.sel = 4'h0; m0_if.dat_ms = 32'h0;
      m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0;
      m1_if.adr = 32'h0; m1_if.sel = 4'h0; m1_if.dat_ms = 32'h0;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [142:0] got, exp;
      logic [31:0]  ea, ed;
      logic [3:0]   es;
      logic         ew;

      // single write/read by m0
      vecs.push_back('{4'b1100, 6'b01_01_01, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 32'h0, 4'h0,
                       4'b0000, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b01_01_01, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 32'h0, 4'h0,
                       4'b0111, 6'b01_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b01_01_00, 32'h10, 32'h0, 4'hF, 32'h0, 32'h0, 4'h0,
                       4'b0111, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b01_01_00, 32'h10, 32'h0, 4'hF, 32'h0, 32'h0, 4'h0,
                       4'b0111, 6'b01_00_00, 32'hDEADBEEF, 32'h0});
      vecs.push_back('{4'b1100, 6'b00_00_00, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0,
                       4'b0100, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b00_00_00, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0,
                       4'b0000, 6'b00_00_00, 32'h0, 32'h0});
      // reset, then simultaneous requests: m0 first, byte-lane write, m1 after dead cycle
      vecs.push_back('{4'b0100, 6'b00_00_00, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0,
                       4'b0000, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b11_11_01, 32'h20, 32'h11223344, 4'h3, 32'h30, 32'h0, 4'hF,
                       4'b0000, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b11_11_01, 32'h20, 32'h11223344, 4'h3, 32'h30, 32'h0, 4'hF,
                       4'b0111, 6'b01_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b11_11_00, 32'h20, 32'h0, 4'hF, 32'h30, 32'h0, 4'hF,
                       4'b0111, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b11_11_00, 32'h20, 32'h0, 4'hF, 32'h30, 32'h0, 4'hF,
                       4'b0111, 6'b01_00_00, 32'hAABB3344, 32'h0});
      vecs.push_back('{4'b1100, 6'b10_10_00, 32'h0, 32'h0, 4'h0, 32'h30, 32'h0, 4'hF,
                       4'b0100, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b10_10_00, 32'h0, 32'h0, 4'h0, 32'h30, 32'h0, 4'hF,
                       4'b0000, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b10_10_00, 32'h0, 32'h0, 4'h0, 32'h30, 32'h0, 4'hF,
                       4'b1011, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b10_10_00, 32'h0, 32'h0, 4'h0, 32'h30, 32'h0, 4'hF,
                       4'b1011, 6'b10_00_00, 32'h0, 32'h5A5A0001});
      vecs.push_back('{4'b1100, 6'b00_00_00, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0,
                       4'b1000, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b00_00_00, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0,
                       4'b0000, 6'b00_00_00, 32'h0, 32'h0});
      // continuous contention: 01, 00, 10, 00, 01
      vecs.push_back('{4'b1100, 6'b11_11_11, 32'h40, 32'h1, 4'hF, 32'h44, 32'h2, 4'hF,
                       4'b0000, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b11_11_11, 32'h40, 32'h1, 4'hF, 32'h44, 32'h2, 4'hF,
                       4'b0111, 6'b01_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b10_10_10, 32'h0, 32'h0, 4'h0, 32'h44, 32'h2, 4'hF,
                       4'b0100, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b11_11_11, 32'h40, 32'h1, 4'hF, 32'h44, 32'h2, 4'hF,
                       4'b0000, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b11_11_11, 32'h40, 32'h1, 4'hF, 32'h44, 32'h2, 4'hF,
                       4'b1011, 6'b10_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b01_01_01, 32'h40, 32'h1, 4'hF, 32'h0, 32'h0, 4'h0,
                       4'b1000, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b11_11_11, 32'h40, 32'h1, 4'hF, 32'h44, 32'h2, 4'hF,
                       4'b0000, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b11_11_11, 32'h40, 32'h1, 4'hF, 32'h44, 32'h2, 4'hF,
                       4'b0111, 6'b01_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b10_10_10, 32'h0, 32'h0, 4'h0, 32'h44, 32'h2, 4'hF,
                       4'b0100, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b00_00_00, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0,
                       4'b0000, 6'b00_00_00, 32'h0, 32'h0});
      // slave rty/err reach the owner only
      vecs.push_back('{4'b1001, 6'b01_01_00, 32'h50, 32'h0, 4'hF, 32'h0, 32'h0, 4'h0,
                       4'b0000, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1001, 6'b01_01_00, 32'h50, 32'h0, 4'hF, 32'h0, 32'h0, 4'h0,
                       4'b0111, 6'b00_00_01, 32'h0, 32'h0});
      vecs.push_back('{4'b1010, 6'b01_01_00, 32'h50, 32'h0, 4'hF, 32'h0, 32'h0, 4'h0,
                       4'b0111, 6'b00_01_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b00_00_00, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0,
                       4'b0100, 6'b00_00_00, 32'h0, 32'h0});
      vecs.push_back('{4'b1100, 6'b00_00_00, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0,
                       4'b0000, 6'b00_00_00, 32'h0, 32'h0});

      // reset state, with m0 already requesting
      rst_n = 1'b0; slv_init = 1'b1; slv_en = 1'b1; slv_err = 1'b0; slv_rty = 1'b0;
      masters_off();
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
      #2;
      check("reset_state", 160'({grant, s_if.cyc, s_if.stb, m0_if.ack, s_if.adr}), 160'(0));
      masters_off();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; slv_init = 1'b0;

      foreach (vecs[i]) begin
         cycle();
         drive(vecs[i]);
         @(negedge clk);
         ea = 32'h0; ed = 32'h0; es = 4'h0; ew = 1'b0;
         if (vecs[i].bus[3:2] == 2'b01) begin
            ea = vecs[i].adr0; ed = vecs[i].dat0; es = vecs[i].sel0; ew = vecs[i].req[0];
         end else if (vecs[i].bus[3:2] == 2'b10) begin
            ea = vecs[i].adr1; ed = vecs[i].dat1; es = vecs[i].sel1; ew = vecs[i].req[1];
         end
         got = {grant, s_if.cyc, s_if.stb, m1_if.ack, m0_if.ack, m1_if.err, m0_if.err,
                m1_if.rty, m0_if.rty, s_if.adr, s_if.dat_ms, s_if.sel, s_if.we,
                m0_if.dat_sm, m1_if.dat_sm};
         exp = {vecs[i].bus, vecs[i].rsp, ea, ed, es, ew, vecs[i].dsm0, vecs[i].dsm1};
         check($sformatf("vec%0d", i), 160'(got), 160'(exp));
      end

      // watchdog: m1 strobe never answered, err exactly at cycle 64 after stb
      cycle();
      slv_en = 1'b0;
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h60;
      for (int k = 1; k <= 70; k++) begin
         cycle();
         @(negedge clk);
         check($sformatf("wdog_k%0d", k), 160'({m0_if.err, m1_if.err, s_if.stb, grant}),
               160'({1'b0, (k == 64), (k != 64), 2'b10}));
      end
      cycle();
      masters_off();
      cycle();

      // registered read ack lands on the watchdog cycle: ack wins, no err
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h10;
      for (int k = 1; k <= 66; k++) begin
         cycle();
         slv_en = (k == 63);
         @(negedge clk);
         check($sformatf("ackwin_k%0d", k), 160'({m0_if.ack, m0_if.err}),
               160'({(k == 64), 1'b0}));
      end
      cycle();
      masters_off();
      slv_en = 1'b1;
      cycle();

      // asynchronous reset during an m1 read with the slave ack pending
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.we = 1'b0; m1_if.adr = 32'h30;
      cycle();
      @(negedge clk);
      check("rst_pre_grant", 160'(grant), 160'(2'b10));
      cycle();
      rst_n = 1'b0;
      #1;
      check("rst_async", 160'({grant, s_if.cyc, s_if.stb, m1_if.ack, m1_if.err, m1_if.dat_sm}),
            160'(0));
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b1;
      m0_if.adr = 32'h70; m0_if.sel = 4'hF; m0_if.dat_ms = 32'h77;
      @(negedge clk);
      check("rst_hold", 160'({grant, s_if.cyc, m0_if.ack, m1_if.ack, m1_if.err}), 160'(0));
      cycle();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_release_idle", 160'({grant, s_if.cyc, m1_if.ack}), 160'(0));
      cycle();
      @(negedge clk);
      check("rst_m0_first", 160'({grant, m0_if.ack, m1_if.ack, m1_if.err}),
            160'({2'b01, 1'b1, 1'b0, 1'b0}));
      cycle();
      masters_off();
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: consecutive wait cycles, with stb high and no slave ack/err/rty, before the watchdog fires; legal range 2..1023.
REQ-002 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port wb_m0, wshb_if.slave, 32-bit data, byte sel[3:0]: requester 0, higher priority after reset.
REQ-005 SHALL have port wb_m1, wshb_if.slave, 32-bit data, byte sel[3:0]: requester 1.
REQ-006 SHALL have port wb_s, wshb_if.master, 32-bit data: shared slave, typically the BRAM controller.
REQ-007 SHALL have port grant, output, 2 bits: one-hot current owner, bit0 = m0, bit1 = m1, 00 = idle.

Function
REQ-008 SHALL implement FSM states IDLE, OWN0, OWN1, state register clocked on posedge clk.
REQ-009 IDLE: m0.cyc only -> OWN0; m1.cyc only -> OWN1; neither -> IDLE.
REQ-010 IDLE with both cyc high: round-robin; the master not served last wins; after reset m0 counts as the winner.
REQ-011 OWN0 stays while m0.cyc=1 and moves to IDLE the cycle after m0.cyc=0; OWN1 follows the same rule for m1. No preemption, no direct OWNx->OWNy transition.
REQ-012 Grant latency: cyc rising in cycle N while IDLE -> grant and slave cyc/stb visible in cycle N+1. One dead IDLE cycle between owners.
REQ-013 In OWNx, wb_s.cyc/stb/we/adr/sel/dat_ms SHALL combinationally equal mx's signals; in IDLE, wb_s.cyc=stb=we=0, sel=0, adr=0, dat_ms=0.
REQ-014 Owner SHALL receive wb_s.ack/err/rty and dat_sm combinationally, with zero added latency.
REQ-015 Non-owner SHALL see ack=err=rty=0 and dat_sm=0.
REQ-016 Watchdog counter: clears on any slave ack/err/rty, on owner stb=0, and on state change; increments each cycle the owner has stb=1 with none of ack/err/rty.
REQ-017 When the watchdog count reaches TIMEOUT-1, the owner SHALL get err=1 for exactly one cycle, wb_s.stb SHALL be forced to 0 that cycle, and the counter SHALL clear.
REQ-018 A slave ack and a watchdog err in the same cycle: ack wins, no err.
REQ-019 Write transactions (slave acks in the stb cycle) and read transactions (slave acks one cycle after stb) SHALL both pass unmodified, including back-to-back stb within one cyc.
REQ-020 grant SHALL equal 2'b01 in OWN0, 2'b10 in OWN1, and 2'b00 in IDLE, decoded from the state only.

Reset
REQ-021 rst_n=0 SHALL immediately force IDLE, grant=00, watchdog=0, last-winner=m1 (so m0 wins next), and all wb_s outputs to 0 without waiting for clk.
REQ-022 Reset asserted mid-transaction SHALL drop the transfer silently: no ack/err to either master. Operation resumes on the first posedge after rst_n rises.

Verification
REQ-023 Only m0 cyc/stb, we=1, adr=0x10, dat=0xDEADBEEF, sel=F -> grant=01 next cycle, m0 ack one cycle later, read of 0x10 returns 0xDEADBEEF to m0 after 2 cycles.
REQ-024 m0 and m1 raise cyc in the same cycle after reset -> m0 served first; after m0 drops cyc, one IDLE cycle, then grant=10; m1 sees no ack while m0 owns.
REQ-025 Both masters request continuously, each issuing single transactions -> grants alternate 01, 00, 10, 00, 01...; neither master starves.
REQ-026 Slave ack tied 0, m1 stb held -> m1 err=1 at cycle TIMEOUT after stb (64 by default), wb_s.stb=0 that cycle, err never repeats on consecutive cycles.
REQ-027 rst_n pulled low during an m1 read with stb high -> grant=00 and wb_s.cyc=0 in the same cycle; no ack to m1; after release, m0 request is granted first.
REQ-028 m0 write with sel=4'b0011, dat=0x11223344 over prior word 0xAABBCCDD -> readback 0xAABB3344 via the arbiter.
